// File: rtl/div_clk_prog.sv
// div_clk_prog
// Runtime-programmable clock divider. Produces a divided waveform with a
// programmable period and high-time, a one-cycle tick at each period start
// and a one-cycle load acknowledge. New settings are held in a shadow copy
// and only take effect at a period boundary, so a retune never cuts a
// period short.
//
// Ports
//   sclk        in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   run enable; when low the counter is held at 0 and the
//                    outputs are low
//   load        in   one-cycle request to capture div_val / high_val
//   div_val     in   requested period in sclk cycles
//   high_val    in   requested high-time in sclk cycles
//   po_div_clk  out  divided clock, registered
//   po_tick     out  one-cycle pulse at each period start, registered
//   load_ack    out  one-cycle pulse, new settings active, registered
module div_clk_prog #(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 4,
    parameter int DEFAULT_HIGH = 2
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_val,
    input  logic [CNT_W-1:0] high_val,
    output logic             po_div_clk,
    output logic             po_tick,
    output logic             load_ack
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_a_q, per_a_d;
    logic [CNT_W-1:0] high_a_q, high_a_d;
    logic [CNT_W-1:0] per_s_q, per_s_d;
    logic [CNT_W-1:0] high_s_q, high_s_d;
    logic             pend_q, pend_d;
    logic             apply_q, apply_d;
    logic             div_clk_q, div_clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;

    logic [CNT_W-1:0] san_per;
    logic [CNT_W-1:0] san_high;
    logic             wrap;

    // Clamp requests so the active settings always describe a legal
    // waveform: period >= 2 and 1 <= high < period.
    always_comb begin
        san_per  = (div_val < TWO) ? TWO : div_val;
        san_high = (high_val == '0) ? ONE : high_val;
        if (san_high >= san_per) begin
            san_high = san_per - ONE;
        end
    end

    assign wrap = (cnt_q == per_a_q - ONE);

    always_comb begin
        cnt_d     = cnt_q;
        per_a_d   = per_a_q;
        high_a_d  = high_a_q;
        per_s_d   = per_s_q;
        high_s_d  = high_s_q;
        pend_d    = pend_q;
        apply_d   = 1'b0;
        div_clk_d = 1'b0;
        tick_d    = 1'b0;

        if (en) begin
            div_clk_d = (cnt_q < high_a_q);
            tick_d    = (cnt_q == '0);
            if (wrap) begin
                cnt_d = '0;
                if (load) begin
                    // A load landing on the boundary goes straight to active.
                    per_a_d  = san_per;
                    high_a_d = san_high;
                    per_s_d  = san_per;
                    high_s_d = san_high;
                    pend_d   = 1'b0;
                    apply_d  = 1'b1;
                end else if (pend_q) begin
                    per_a_d  = per_s_q;
                    high_a_d = high_s_q;
                    pend_d   = 1'b0;
                    apply_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + ONE;
                if (load) begin
                    per_s_d  = san_per;
                    high_s_d = san_high;
                    pend_d   = 1'b1;
                end
            end
        end else begin
            cnt_d = '0;
            // While stopped there is no boundary to wait for: a pending
            // setting goes active on the next edge without a fresh load.
            if (load) begin
                per_s_d  = san_per;
                high_s_d = san_high;
                pend_d   = 1'b1;
            end else if (pend_q) begin
                per_a_d  = per_s_q;
                high_a_d = high_s_q;
                pend_d   = 1'b0;
                apply_d  = 1'b1;
            end
        end
    end

    // The acknowledge is delayed one edge past the application so it lines
    // up with the first tick of the new period.
    assign ack_d = apply_q;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            per_a_q   <= DIV_RST;
            high_a_q  <= HIGH_RST;
            per_s_q   <= DIV_RST;
            high_s_q  <= HIGH_RST;
            pend_q    <= 1'b0;
            apply_q   <= 1'b0;
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_a_q   <= per_a_d;
            high_a_q  <= high_a_d;
            per_s_q   <= per_s_d;
            high_s_q  <= high_s_d;
            pend_q    <= pend_d;
            apply_q   <= apply_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
        end
    end

    assign po_div_clk = div_clk_q;
    assign po_tick    = tick_q;
    assign load_ack   = ack_q;

endmodule

// File: doc/div_clk_prog.md
# div_clk_prog

Runtime-programmable clock divider: generalises the fixed divide-by-4 generator to a CNT_W-bit period and independent high-time, both updatable while running. New settings are applied glitch-free at the period boundary. Besides the divided waveform it emits a one-cycle period-start tick and a load acknowledge. It sits between the system clock and the tone and LED-scan logic, which retune pitch or scan rate on the fly.

## Interface
- CNT_W, 16: width of the period, high-time and internal counter.
- DEFAULT_DIV, 4: period in sclk cycles after reset. Must be ≥2.
- DEFAULT_HIGH, 2: high-time in sclk cycles after reset. Must be 1..DEFAULT_DIV-1.
- sclk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- en  in  1  run enable. When 0, the counter is held at 0 and the outputs are forced low.
- load  in  1  one-cycle request to capture div_val/high_val.
- div_val  in  CNT_W  requested period in sclk cycles.
- high_val  in  CNT_W  requested high-time in sclk cycles.
- po_div_clk  out  1  divided clock, registered.
- po_tick  out  1  one-cycle pulse coincident with each rising period start, registered.
- load_ack  out  1  one-cycle pulse: new settings have become active, registered.

## Operation
- Active registers: per_a and high_a. Shadow registers: per_s and high_s, plus a pending flag.
- Counter cnt runs 0..per_a-1 on each enabled edge.
  - Wrap condition: cnt == per_a-1, then cnt ← 0.
  - Otherwise cnt ← cnt+1.
- Output on each enabled edge:
  - po_div_clk ← (cnt < high_a).
  - po_tick ← (cnt == 0).
- Sanitising on capture, evaluated in order:
  - div_val < 2 → per = 2.
  - high_val == 0 → high = 1.
  - high_val ≥ per → high = per-1.
- load=1: sanitised values are written to the shadow registers and pending is set. A later load before application overwrites the shadow (last load wins).
- Application when en=1: at the wrap edge, if pending, shadow → active, cnt ← 0, pending cleared, load_ack ← 1.
- load and wrap on the same edge: the incoming values bypass the shadow and become active at that edge; load_ack ← 1.
- Application when en=0: pending is applied on the next edge and load_ack pulses; a load while en=0 is applied at the following edge.
- en 1→0: on that edge cnt ← 0, po_div_clk ← 0, po_tick ← 0. Active settings are retained.
- en 0→1: the first enabled edge sees cnt=0, so po_div_clk and po_tick both go to 1 after that edge.
- Arithmetic is unsigned CNT_W. The counter never exceeds per_a-1, so there is no overflow; the maximum period is 2^CNT_W-1.

## Timing
- Reset values:
  - cnt=0, per_a=per_s=DEFAULT_DIV, high_a=high_s=DEFAULT_HIGH, pending=0.
  - po_div_clk=0, po_tick=0, load_ack=0.
- Latency: the outputs lag the counter by one edge. The first po_div_clk rise is one edge after the first enabled edge following rst_n release.
- Waveform: high for exactly high_a cycles, low for per_a-high_a cycles, repeating with period per_a.
- Settings change: the old period always completes, so there is no runt pulse. The new first high phase starts on the edge after load_ack's launch edge, i.e. po_tick and load_ack assert in the same cycle.
- Worst-case change latency is per_a cycles after load.
- Reset mid-period: all state returns to reset values immediately. Pending loads are discarded; no load_ack is issued.

## Test plan
- Reset release, en=1, defaults:
  - po_div_clk = 1,1,0,0 repeating.
  - po_tick high every 4th cycle, aligned with each rise.
- Running at period 4 (defaults), load div_val=10, high_val=3 at mid-period:
  - The current 4-cycle period finishes intact.
  - load_ack and po_tick pulse together.
  - Output then runs 3 high / 7 low.
- Sanitising: load div_val=1, high_val=0 → period 2, high 1. Then load div_val=5, high_val=9 → period 5, high 4.
- Two loads before the boundary: load (8,4) then (6,1).
  - Only (6,1) is applied.
  - Exactly one load_ack.
- Load on the wrap edge with (12,6) → applied at that edge with no extra period; en=0 for 3 cycles then 1 → output low while disabled, then high for 6 from cnt=0.
- Assert rst_n low mid-high-phase with a load pending → all outputs 0 asynchronously. After release the defaults run and no load_ack appears.
